tlc_phase_arbiter: RTL
======================

TLC_PHASE_ARBITER -- requirements
Module: tlc_phase_arbiter

Interface
REQ-001 SHALL take parameter NUM_PHASES, default 5: number of mutually conflicting phases; legal range 2..16.
REQ-002 SHALL take parameter GAP_CYCLES, default 5: green cycles granted after own demand first drops; legal range >=1.
REQ-003 SHALL take parameter MAX_CYCLES, default 10: green cycles granted after conflicting demand first appears; legal range >=1.
REQ-004 SHALL take parameter YELLOW_CYCLES, default 2: yellow duration; legal range >=1.
REQ-005 SHALL take parameter ALLRED_CYCLES, default 1: minimum all-red duration after each yellow; legal range >=1.
REQ-006 SHALL define IW = max(1, $clog2(NUM_PHASES)).
REQ-007 clk  input  1  clock; all state updates on its rising edge.
REQ-008 reset  input  1  reset, synchronous, active-high.
REQ-009 demand  input  NUM_PHASES  per-phase aggregated sensor demand, bit i = phase i.
REQ-010 preempt_req  input  1  emergency preemption request, level-sensitive.
REQ-011 preempt_phase  input  IW  target phase of preemption; values >= NUM_PHASES SHALL be treated as preempt_req=0.
REQ-012 green  output  NUM_PHASES  one-hot or zero; bit i = phase i green.
REQ-013 yellow  output  NUM_PHASES  one-hot or zero; bit i = phase i yellow.
REQ-014 active_phase  output  IW  phase last granted green; red is implied wherever green and yellow are both 0.
REQ-015 preempt_active  output  1  high while the FSM serves a valid preemption (forced yellow, all-red toward target, or target green).

Function
REQ-016 SHALL implement a Moore FSM with states GREEN, YELLOW and ALLRED; outputs SHALL depend only on registered state.
REQ-017 At most one bit of green|yellow SHALL be high in any cycle; green and yellow SHALL never both be high.
REQ-018 GREEN, gap_cnt: cleared on green entry; increments when gap_cnt!=0 or demand[active]==0; otherwise holds.
REQ-019 GREEN, max_cnt: cleared on green entry; increments when max_cnt!=0 or any demand[j], j!=active, is 1; otherwise holds.
REQ-020 GREEN SHALL move to YELLOW on the cycle after gap_cnt==GAP_CYCLES-1 or max_cnt==MAX_CYCLES-1 is observed; both counters SHALL then clear.
REQ-021 YELLOW SHALL last exactly YELLOW_CYCLES cycles on the same phase, then move to ALLRED.
REQ-022 ALLRED SHALL last at least ALLRED_CYCLES cycles; ar_cnt SHALL saturate at ALLRED_CYCLES-1.
REQ-023 At ALLRED with ar_cnt saturated, the FSM SHALL select the first phase with demand, searching active_phase+1, +2, ... modulo NUM_PHASES, with active_phase itself last.
REQ-024 On a selection, the next cycle SHALL be GREEN on that phase and active_phase SHALL update; with no demand, the FSM SHALL remain in ALLRED indefinitely.
REQ-025 Preempt during GREEN of a different phase: the next cycle SHALL be YELLOW, ignoring counters; YELLOW and ALLRED timing SHALL be unchanged.
REQ-026 Preempt at the ALLRED selection point: the target SHALL be selected regardless of demand.
REQ-027 Preempt during GREEN of the target: green SHALL hold and both counters SHALL stay 0 for as long as preempt_req=1.
REQ-028 On preempt_req deassertion, counting SHALL resume from 0 under REQ-018..020.
REQ-029 preempt_phase changing mid-preemption SHALL retarget at the next selection point only.
REQ-030 All counters SHALL be sized to their parameter and SHALL never wrap.

Reset
REQ-031 With reset=1 at a clock edge, the FSM SHALL enter ALLRED with ar_cnt saturated, active_phase=NUM_PHASES-1, and all counters 0.
REQ-032 In that reset state green=0, yellow=0 and preempt_active=0, and the next selection SHALL start from phase 0.
REQ-033 Reset SHALL override any state, including mid-yellow and mid-preemption.

Verification
REQ-034 Reset, demand=0 for 20 cycles -> green=0, yellow=0 throughout; then demand=5'b00100 at edge t -> green=5'b00100 from edge t+1.
REQ-035 demand[0] pulsed for 1 cycle (defaults) -> green[0] for 5 cycles, yellow[0] for 2, all-red 1, then idle all-red.
REQ-036 demand[0] and demand[3] held -> green[0] 10 cycles, yellow 2, all-red 1, green[3] 10 cycles, then back to phase 0.
REQ-037 active_phase=1 at the selection point, demand=5'b10001 -> phase 4 granted, not phase 0.
REQ-038 green[1] active, preempt_req=1 with preempt_phase=3 -> yellow[1] next cycle for 2 cycles, all-red 1, green[3] held for the whole request; release -> normal gap/max timing applies.
REQ-039 reset asserted during yellow[2] -> next cycle all outputs 0 and active_phase=4.

Source files
------------

// File: rtl/tlc_phase_arbiter.sv
// ---------------------------------------------------------------------------
// tlc_phase_arbiter
//   Traffic-light phase arbiter for NUM_PHASES mutually conflicting phases.
//   A Moore FSM (GREEN -> YELLOW -> ALLRED) grants green to one phase at a
//   time. Green ends on gap-out (own demand gone for GAP_CYCLES) or max-out
//   (conflicting demand waiting for MAX_CYCLES). An emergency preemption
//   forces the sequence toward a target phase and holds it green.
//
// Ports
//   clk            : clock, rising-edge
//   reset          : synchronous, active-high
//   demand         : per-phase sensor demand, bit i = phase i
//   preempt_req    : emergency preemption request (level)
//   preempt_phase  : preemption target; out-of-range values are ignored
//   green          : one-hot or zero green indication
//   yellow         : one-hot or zero yellow indication
//   active_phase   : phase most recently granted green
//   preempt_active : FSM is currently serving a valid preemption
// ---------------------------------------------------------------------------
module tlc_phase_arbiter #(
    parameter int NUM_PHASES    = 5,
    parameter int GAP_CYCLES    = 5,
    parameter int MAX_CYCLES    = 10,
    parameter int YELLOW_CYCLES = 2,
    parameter int ALLRED_CYCLES = 1,
    localparam int IW = ($clog2(NUM_PHASES) < 1) ? 1 : $clog2(NUM_PHASES)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_PHASES-1:0] demand,
    input  logic                  preempt_req,
    input  logic [IW-1:0]         preempt_phase,
    output logic [NUM_PHASES-1:0] green,
    output logic [NUM_PHASES-1:0] yellow,
    output logic [IW-1:0]         active_phase,
    output logic                  preempt_active
);

    // Counters only ever reach PARAM-1, so they are sized for that range.
    localparam int GW = ($clog2(GAP_CYCLES)    < 1) ? 1 : $clog2(GAP_CYCLES);
    localparam int MW = ($clog2(MAX_CYCLES)    < 1) ? 1 : $clog2(MAX_CYCLES);
    localparam int YW = ($clog2(YELLOW_CYCLES) < 1) ? 1 : $clog2(YELLOW_CYCLES);
    localparam int AW = ($clog2(ALLRED_CYCLES) < 1) ? 1 : $clog2(ALLRED_CYCLES);

    typedef enum logic [1:0] {
        ST_GREEN  = 2'd0,
        ST_YELLOW = 2'd1,
        ST_ALLRED = 2'd2
    } state_t;

    state_t          st_q, st_d;
    logic [IW-1:0]   active_q, active_d;
    logic [GW-1:0]   gap_cnt_q, gap_cnt_d;
    logic [MW-1:0]   max_cnt_q, max_cnt_d;
    logic [YW-1:0]   y_cnt_q, y_cnt_d;
    logic [AW-1:0]   ar_cnt_q, ar_cnt_d;
    logic            pre_act_q, pre_act_d;

    // Round-robin search starting after the current phase; the current
    // phase itself is examined last. Returns {found, index}.
    function automatic logic [IW:0] pick_next(input logic [IW-1:0]         cur,
                                              input logic [NUM_PHASES-1:0] dem);
        logic          found;
        logic [IW-1:0] sel;
        int            idx;
        found = 1'b0;
        sel   = cur;
        for (int k = 1; k <= NUM_PHASES; k++) begin
            idx = (int'(cur) + k) % NUM_PHASES;
            if (!found && dem[idx]) begin
                found = 1'b1;
                sel   = IW'(idx);
            end
        end
        return {found, sel};
    endfunction

    logic                  pre_valid;
    logic [NUM_PHASES-1:0] active_onehot;
    logic                  own_demand;
    logic                  conflict_demand;
    logic [IW:0]           pick;

    always_comb begin
        pre_valid       = preempt_req && (int'(preempt_phase) < NUM_PHASES);
        active_onehot   = NUM_PHASES'(1) << active_q;
        own_demand      = |(demand & active_onehot);
        conflict_demand = |(demand & ~active_onehot);
        pick            = pick_next(active_q, demand);
    end

    always_comb begin
        st_d      = st_q;
        active_d  = active_q;
        gap_cnt_d = gap_cnt_q;
        max_cnt_d = max_cnt_q;
        y_cnt_d   = y_cnt_q;
        ar_cnt_d  = ar_cnt_q;
        // Preemption status is simply the registered validity of the
        // request: every state reached while it is valid is part of serving it.
        pre_act_d = pre_valid;

        case (st_q)
            ST_GREEN: begin
                if (pre_valid && (preempt_phase != active_q)) begin
                    st_d      = ST_YELLOW;
                    gap_cnt_d = '0;
                    max_cnt_d = '0;
                    y_cnt_d   = '0;
                end else if (pre_valid) begin
                    // Target already green: freeze timing until release.
                    gap_cnt_d = '0;
                    max_cnt_d = '0;
                end else if ((gap_cnt_q == GW'(GAP_CYCLES - 1)) ||
                             (max_cnt_q == MW'(MAX_CYCLES - 1))) begin
                    st_d      = ST_YELLOW;
                    gap_cnt_d = '0;
                    max_cnt_d = '0;
                    y_cnt_d   = '0;
                end else begin
                    // Once started, each timer keeps running even if the
                    // triggering condition goes away.
                    if ((gap_cnt_q != '0) || !own_demand)
                        gap_cnt_d = gap_cnt_q + GW'(1);
                    if ((max_cnt_q != '0) || conflict_demand)
                        max_cnt_d = max_cnt_q + MW'(1);
                end
            end
            ST_YELLOW: begin
                if (y_cnt_q == YW'(YELLOW_CYCLES - 1)) begin
                    st_d     = ST_ALLRED;
                    y_cnt_d  = '0;
                    ar_cnt_d = '0;
                end else begin
                    y_cnt_d = y_cnt_q + YW'(1);
                end
            end
            default: begin
                if (ar_cnt_q != AW'(ALLRED_CYCLES - 1)) begin
                    ar_cnt_d = ar_cnt_q + AW'(1);
                end else if (pre_valid) begin
                    st_d     = ST_GREEN;
                    active_d = preempt_phase;
                end else if (pick[IW]) begin
                    st_d     = ST_GREEN;
                    active_d = pick[IW-1:0];
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            st_q      <= ST_ALLRED;
            active_q  <= IW'(NUM_PHASES - 1);
            gap_cnt_q <= '0;
            max_cnt_q <= '0;
            y_cnt_q   <= '0;
            ar_cnt_q  <= AW'(ALLRED_CYCLES - 1);
            pre_act_q <= 1'b0;
        end else begin
            st_q      <= st_d;
            active_q  <= active_d;
            gap_cnt_q <= gap_cnt_d;
            max_cnt_q <= max_cnt_d;
            y_cnt_q   <= y_cnt_d;
            ar_cnt_q  <= ar_cnt_d;
            pre_act_q <= pre_act_d;
        end
    end

    always_comb begin
        green          = (st_q == ST_GREEN)  ? (NUM_PHASES'(1) << active_q) : '0;
        yellow         = (st_q == ST_YELLOW) ? (NUM_PHASES'(1) << active_q) : '0;
        active_phase   = active_q;
        preempt_active = pre_act_q;
    end

endmodule
